// File: rtl/pwm_audio_mixer.sv
// Multi-channel square-wave tone mixer with a single-bit PWM audio output.
// Channel square waves are summed by volume, saturated, latched per frame and PWM-encoded.
module pwm_audio_mixer #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned VOL_W  = 8,
  parameter int unsigned N_W    = 10,
  parameter int unsigned PWM_W  = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH*N_W-1:0]   N,
  input  logic [NUM_CH*VOL_W-1:0] volume,
  output logic                    sout,
  output logic                    refresh
);

  localparam int unsigned SumW = VOL_W + $clog2(NUM_CH) + 1;
  localparam int unsigned CmpW = (SumW > PWM_W) ? SumW : PWM_W;
  localparam logic [CmpW-1:0] MixMax = CmpW'({PWM_W{1'b1}});

  logic [N_W-1:0]    tone_cnt_q [NUM_CH];
  logic [N_W-1:0]    tone_cnt_d [NUM_CH];
  logic [NUM_CH-1:0] sq_q, sq_d;
  logic [PWM_W-1:0]  mix_q, mix_d;
  logic [PWM_W-1:0]  duty_q, duty_d;
  logic [PWM_W-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic              sout_q, sout_d;
  logic              refresh_q, refresh_d;
  logic [CmpW-1:0]   sum;

  // The >= compare lets a shrinking half-period wrap immediately.
  always_comb begin
    sq_d = sq_q;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      tone_cnt_d[c] = tone_cnt_q[c] + N_W'(1);
      if (!en[c] || (N[c*N_W +: N_W] == '0)) begin
        tone_cnt_d[c] = '0;
        sq_d[c]       = 1'b0;
      end else if (tone_cnt_q[c] >= (N[c*N_W +: N_W] - N_W'(1))) begin
        tone_cnt_d[c] = '0;
        sq_d[c]       = ~sq_q[c];
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (sq_q[c]) begin
        sum = sum + CmpW'(volume[c*VOL_W +: VOL_W]);
      end
    end
    mix_d = (sum > MixMax) ? MixMax[PWM_W-1:0] : sum[PWM_W-1:0];
  end

  // Duty only changes on the last slot so a frame never glitches.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
    duty_d    = (pwm_cnt_q == '1) ? mix_q : duty_q;
    sout_d    = (pwm_cnt_q < duty_q);
    refresh_d = (pwm_cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        tone_cnt_q[c] <= '0;
      end
      sq_q      <= '0;
      mix_q     <= '0;
      duty_q    <= '0;
      pwm_cnt_q <= '0;
      sout_q    <= 1'b0;
      refresh_q <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        tone_cnt_q[c] <= tone_cnt_d[c];
      end
      sq_q      <= sq_d;
      mix_q     <= mix_d;
      duty_q    <= duty_d;
      pwm_cnt_q <= pwm_cnt_d;
      sout_q    <= sout_d;
      refresh_q <= refresh_d;
    end
  end

  assign sout    = sout_q;
  assign refresh = refresh_q;

endmodule
